// File: rtl/req_ack_fifo_responder_pkg.sv
// Shared handshake constants and width helper for the req/ack FIFO responder.
package req_ack_fifo_responder_pkg;

   // Idle cycles forced between two acks; one gives the alternating-cycle ack pattern.
   localparam int HS_MIN_ACK_GAP = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/req_ack_fifo_responder_sync_fifo_core.sv
// Synchronous FIFO with registered occupancy and a combinational head-word view.
module sync_fifo_core
   import req_ack_fifo_responder_pkg::*;
#(
   parameter int data_width = 32,
   parameter int depth      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic [data_width-1:0]     i_wr_data,
   input  logic                      i_pop,
   output logic [data_width-1:0]     o_rd_data,
   output logic                      o_full,
   output logic                      o_empty,
   output logic [clog2(depth):0]     o_level
);

   localparam int PW = clog2(depth);
   localparam int LW = PW + 1;

   logic [data_width-1:0] r_mem [depth];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;

   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;

   assign w_full    = (r_level == LW'(depth));
   assign w_empty   = (r_level == '0);
   // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
   assign w_push_ok = i_push & ~w_full;
   assign w_pop_ok  = i_pop & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push_ok && !rst) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_level   = r_level;

endmodule

// File: rtl/req_ack_fifo_responder.sv
// Answers a level req with single-cycle ack pulses, handing out pre-loaded FIFO words on dout.
module req_ack_fifo_responder
   import req_ack_fifo_responder_pkg::*;
#(
   parameter int                    data_width    = 32,
   parameter int                    depth         = 8,
   parameter logic [data_width-1:0] initial_value = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [data_width-1:0]     wr_data,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(depth):0]     level,
   input  logic                      req,
   output logic                      ack,
   output logic [data_width-1:0]     dout,
   output logic [31:0]               count
);

   logic [HS_MIN_ACK_GAP-1:0] r_ack_hist;
   logic [data_width-1:0]     r_dout;
   logic [31:0]               r_count;

   logic                      w_pop;
   logic [data_width-1:0]     w_head;
   logic                      w_empty;
   logic                      w_full;
   logic [clog2(depth):0]     w_level;

   sync_fifo_core #(
      .data_width (data_width),
      .depth      (depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (wr_en),
      .i_wr_data (wr_data),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (w_level)
   );

   // Pop only when no ack was issued in the last HS_MIN_ACK_GAP cycles.
   assign w_pop = req & ~(|r_ack_hist) & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack_hist <= '0;
         r_dout     <= initial_value;
         r_count    <= '0;
      end else begin
         r_ack_hist <= (r_ack_hist << 1) | HS_MIN_ACK_GAP'(w_pop);
         if (w_pop) begin
            r_dout  <= w_head;
            r_count <= r_count + 32'd1;
         end
      end
   end

   assign ack   = r_ack_hist[0];
   assign dout  = r_dout;
   assign count = r_count;
   assign full  = w_full;
   assign empty = w_empty;
   assign level = w_level;

endmodule

// File: tb/tb_req_ack_fifo_responder.sv
// Directed self-checking bench for req_ack_fifo_responder (data_width=32, depth=8).
module tb_req_ack_fifo_responder;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        full;
   logic        empty;
   logic [3:0]  level;
   logic        req;
   logic        ack;
   logic [31:0] dout;
   logic [31:0] count;

   int n_assert;
   int n_fail;
   logic [31:0] got [$];

   req_ack_fifo_responder #(
      .data_width    (32),
      .depth         (8),
      .initial_value (32'd0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .req     (req),
      .ack     (ack),
      .dout    (dout),
      .count   (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   // Hold req high until n acks are seen or the cycle budget runs out.
   task automatic drain(input int n);
      logic prev_ack;
      int   cycles;
      got.delete();
      req      = 1'b1;
      prev_ack = ack;
      cycles   = 0;
      while (got.size() < n && cycles < 4 * n + 8) begin
         tick();
         cycles++;
         if (ack) got.push_back(dout);
         check_eq("ack_gap", {31'd0, prev_ack & ack}, 32'd0);
         prev_ack = ack;
      end
      req = 1'b0;
      check_eq("drain_n", got.size(), n);
   endtask

   initial begin
      logic [31:0] exp_q [$];
      logic        exp_ack [8];
      logic [31:0] exp_dout [8];

      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      wr_en    = 1'b0;
      wr_data  = '0;
      req      = 1'b0;

      // Reset state
      tick();
      tick();
      check_eq("rst_ack", {31'd0, ack}, 32'd0);
      check_eq("rst_dout", dout, 32'd0);
      check_eq("rst_count", count, 32'd0);
      check_eq("rst_level", {28'd0, level}, 32'd0);
      check_eq("rst_empty", {31'd0, empty}, 32'd1);
      check_eq("rst_full", {31'd0, full}, 32'd0);

      // Reset mid-stream discards data and suppresses the pending ack
      rst = 1'b0;
      push(32'd1);
      push(32'd2);
      push(32'd3);
      check_eq("pre_rst_level", {28'd0, level}, 32'd3);
      rst     = 1'b1;
      req     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'd4;
      tick();
      rst   = 1'b0;
      wr_en = 1'b0;
      check_eq("mid_rst_ack", {31'd0, ack}, 32'd0);
      check_eq("mid_rst_dout", dout, 32'd0);
      check_eq("mid_rst_level", {28'd0, level}, 32'd0);
      check_eq("mid_rst_empty", {31'd0, empty}, 32'd1);
      check_eq("mid_rst_count", count, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("post_rst_noack", {31'd0, ack}, 32'd0);
      end
      req = 1'b0;

      // Ordered drain: acks on alternating cycles
      push(32'd10);
      push(32'd11);
      push(32'd12);
      exp_ack  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_dout = '{32'd10, 32'd10, 32'd11, 32'd11, 32'd12, 32'd12, 32'd12, 32'd12};
      req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("drain_ack", {31'd0, ack}, {31'd0, exp_ack[i]});
         check_eq("drain_dout", dout, exp_dout[i]);
      end
      req = 1'b0;
      check_eq("drain_count", count, 32'd3);
      check_eq("drain_empty", {31'd0, empty}, 32'd1);

      // Full boundary: ninth word dropped
      for (int i = 0; i < 8; i++) push(32'(i));
      check_eq("full_after8", {31'd0, full}, 32'd1);
      check_eq("level_after8", {28'd0, level}, 32'd8);
      push(32'd8);
      check_eq("level_after9", {28'd0, level}, 32'd8);
      drain(8);
      for (int i = 0; i < got.size(); i++) check_eq("full_data", got[i], 32'(i));
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("empty_noack", {31'd0, ack}, 32'd0);
      end
      req = 1'b0;
      check_eq("full_count", count, 32'd11);

      // Push and pop together at full, then at level 7
      for (int i = 0; i < 8; i++) push(32'd20 + 32'(i));
      req     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'd99;
      tick();
      check_eq("pp_full_level", {28'd0, level}, 32'd7);
      check_eq("pp_full_ack", {31'd0, ack}, 32'd1);
      check_eq("pp_full_dout", dout, 32'd20);
      wr_en = 1'b0;
      tick();
      check_eq("pp_gap_ack", {31'd0, ack}, 32'd0);
      wr_en   = 1'b1;
      wr_data = 32'd77;
      tick();
      wr_en = 1'b0;
      check_eq("pp7_level", {28'd0, level}, 32'd7);
      check_eq("pp7_dout", dout, 32'd21);
      drain(7);
      exp_q = '{32'd22, 32'd23, 32'd24, 32'd25, 32'd26, 32'd27, 32'd77};
      for (int i = 0; i < got.size(); i++) check_eq("pp7_data", got[i], exp_q[i]);
      check_eq("pp7_empty", {31'd0, empty}, 32'd1);

      // No bypass: word pushed into empty FIFO acked one edge later
      req     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'hA5;
      tick();
      wr_en = 1'b0;
      check_eq("nobypass_ackN", {31'd0, ack}, 32'd0);
      check_eq("nobypass_level", {28'd0, level}, 32'd1);
      tick();
      check_eq("nobypass_ackN1", {31'd0, ack}, 32'd1);
      check_eq("nobypass_dout", dout, 32'hA5);
      req = 1'b0;
      tick();

      // Wrap: 20 words through 8 entries after a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("wrap_count0", count, 32'd0);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 5; k++) push(32'd100 + 32'(5 * c + k));
         drain(5);
         for (int k = 0; k < got.size(); k++) check_eq("wrap_data", got[k], 32'd100 + 32'(5 * c + k));
      end
      check_eq("wrap_count", count, 32'd20);
      check_eq("wrap_level", {28'd0, level}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/req_ack_fifo_responder.md
Name: req_ack_fifo_responder

Overview:
- Buffered responder for the pull-style req/ack dataflow handshake that the array operators and consumers use on their input side.
- A host (bench stimulus or upstream stream logic) pushes words into an internal FIFO with a write-enable/full interface.
- The block answers a downstream requester's level `req` with single-cycle `ack` pulses. `dout` is updated on the same edge that `ack` is asserted.
- It replaces free-running counting producers wherever an exact, pre-loaded data sequence must be fed into an operator graph.

Parameters:
- data_width, 32, width of each data word.
- depth, 8, FIFO entries; must be a power of two, minimum 2.
- initial_value, 0, value driven on `dout` after reset and before the first ack.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  host push strobe; one word per cycle.
- wr_data  input  data_width  word to push.
- full  output  1  FIFO holds `depth` words.
- empty  output  1  FIFO holds 0 words.
- level  output  $clog2(depth)+1  current occupancy.
- req  input  1  level request from the downstream requester.
- ack  output  1  one-cycle acknowledge; `dout` is valid from this edge.
- dout  output  data_width  word handed out; held until the next ack.
- count  output  32  number of acks issued since reset.

Behaviour:
- Reset values (while `rst` is high at a clock edge):
  - `ack`=0, `dout`=initial_value, `count`=0, `level`=0, `empty`=1, `full`=0.
  - Read and write pointers are 0.
  - `wr_en` is ignored during reset.
- Push:
  - On an edge with wr_en=1 and full=0, `wr_data` is written at the write pointer.
  - The write pointer increments modulo depth.
  - `full` is evaluated from registered occupancy. A push while full=1 is dropped, even if a pop occurs in the same cycle, and no state changes.
- Pop / ack rule:
  - On an edge where req=1, ack=0 and empty=0, the next cycle has ack=1.
  - On that same edge, `dout` is loaded with the word at the read pointer, the read pointer increments modulo depth, and `count` increments.
  - In every other cycle ack=0.
- Consequences of the ack rule:
  - `ack` never stays high for two consecutive cycles.
  - With `req` held high, the peak rate is one word every 2 cycles.
  - `ack` is never asserted while the FIFO is empty; `req` may stay high indefinitely with no effect.
- Requester timing:
  - The requester may drop `req` at any time. Dropping it in the cycle an ack appears does not cancel that ack.
  - A request that is never acked leaves no residue.
- `dout` stability: `dout` changes only on an ack edge, so data is stable from the edge where `ack` rises until the next ack. This is valid for requesters that capture on the rising edge of `ack`.
- Occupancy:
  - `level` next = level + push_accepted − pop.
  - Push and pop in the same cycle leave `level` unchanged.
  - `empty` = (level==0) and `full` = (level==depth), both derived from the registered level.
- No bypass: a word pushed into an empty FIFO is first eligible for pop on the following edge, giving a minimum push-to-ack latency of 2 edges.
- Wrap-around:
  - Pointers wrap cleanly at depth.
  - `count` wraps modulo 2^32 with no flag.
- Reset mid-operation: all buffered data is discarded and outputs return to their reset values on that edge. An ack pending in that cycle is suppressed.

Decomposition:
- Shared package holds the handshake constant HS_MIN_ACK_GAP=1 and a `clog2` function used for the `level` and pointer widths.
- One sub-module: `sync_fifo_core`, parameterised by data_width and depth.
  - Provides the storage array, pointers, level, full and empty.
  - Has push/pop strobes and a read-data output that shows the head word combinationally.
- The top level holds only the ack/dout/count registers and the pop qualifier.

Test Plan:
- Reset: push 3 words, then pulse rst mid-stream → next cycle ack=0, dout=0, level=0, empty=1, count=0, and no further acks with req=1.
- Ordered drain: push 10,11,12 with req=0, then hold req=1 → acks on alternating cycles with dout 10,11,12 in order, count=3, then ack stays 0 while empty.
- Full boundary, depth=8: push 9 words 0..8 → full=1 after 8 pushes, word 8 dropped, level=8; draining yields 0..7 only.
- Simultaneous push/pop at full: with level=8, req=1 and wr_en=1 on the pop edge → push dropped, level=7. Repeat at level=7 → level stays 7 and the pushed word appears after 7 more acks.
- Empty no-bypass: with the FIFO empty and req=1, push 0xA5 at edge N → ack=1 with dout=0xA5 after edge N+1, never at N.
- Wrap: push and drain 20 words 100..119 through depth=8 → all 20 received in order, pointers wrapped twice, count=20.
